// File: rtl/fix_length_p2b.sv
// fix_length_p2b: serializes fixed-length packets of wide symbols back into
// bytes (MSB byte first), checking packet framing and length on the way and
// keeping a count of correctly framed packets.
module fix_length_p2b #(
    parameter int SYMBOL_PER_PACKET = 4,
    parameter int BYTES_PER_SYMBOL  = 4,
    parameter int BITS_PER_BYTES    = 8
) (
    input  logic                                     clock_clk,
    input  logic                                     reset_reset,
    input  logic [BYTES_PER_SYMBOL*BITS_PER_BYTES-1:0] asi_in0_data,
    input  logic                                     asi_in0_valid,
    output logic                                     asi_in0_ready,
    input  logic                                     asi_in0_startofpacket,
    input  logic                                     asi_in0_endofpacket,
    output logic [BITS_PER_BYTES-1:0]                aso_out0_data,
    output logic                                     aso_out0_valid,
    input  logic                                     aso_out0_ready,
    output logic                                     aso_out0_startofpacket,
    output logic                                     aso_out0_endofpacket,
    output logic                                     err_framing,
    output logic                                     err_length,
    output logic [15:0]                              pkt_count
);

    localparam int SW = BYTES_PER_SYMBOL * BITS_PER_BYTES;
    localparam int CW = $clog2(SYMBOL_PER_PACKET) + 1;
    localparam int IW = $clog2(BYTES_PER_SYMBOL) + 1;

    typedef enum logic {HUNT, BODY} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_symCnt;
    logic [SW-1:0]       r_hold;
    logic                r_busy;
    logic [IW-1:0]       r_idx;
    logic                r_sopFlag;
    logic                r_eopFlag;
    logic                r_errFraming;
    logic                r_errLength;
    logic [15:0]         r_pktCount;

    logic                w_lastByte;
    logic                w_inXfer;
    logic                w_outXfer;
    logic                w_load;
    logic                w_loadSop;
    logic                w_loadEop;
    logic                w_errFraming;
    logic                w_errLength;
    logic                w_pktInc;
    state_t              w_nextState;
    logic [CW-1:0]       w_nextCnt;
    logic [BITS_PER_BYTES-1:0] w_byte;

    assign w_lastByte = (r_idx == IW'(BYTES_PER_SYMBOL - 1));

    // Ready is combinational so a new symbol can load on the same edge the
    // last byte of the previous one leaves, keeping the output gapless.
    assign asi_in0_ready = !reset_reset && (!r_busy || (aso_out0_ready && w_lastByte));
    assign w_inXfer      = asi_in0_valid && asi_in0_ready;
    assign w_outXfer     = r_busy && aso_out0_ready;

    // Framing decision for the symbol accepted this cycle.
    always_comb begin
        w_load       = 1'b0;
        w_loadSop    = 1'b0;
        w_loadEop    = 1'b0;
        w_errFraming = 1'b0;
        w_errLength  = 1'b0;
        w_pktInc     = 1'b0;
        w_nextState  = r_state;
        w_nextCnt    = r_symCnt;
        if (w_inXfer) begin
            if (r_state == HUNT && !asi_in0_startofpacket) begin
                w_errFraming = 1'b1;
            end else if (asi_in0_startofpacket) begin
                w_load       = 1'b1;
                w_loadSop    = 1'b1;
                w_errFraming = (r_state == BODY);
                w_nextCnt    = CW'(1);
                if (asi_in0_endofpacket) begin
                    w_loadEop   = 1'b1;
                    w_errLength = 1'b1;
                    w_nextState = HUNT;
                end else begin
                    w_nextState = BODY;
                end
            end else begin
                w_load = 1'b1;
                if ((r_symCnt + CW'(1)) == CW'(SYMBOL_PER_PACKET)) begin
                    w_loadEop   = 1'b1;
                    w_nextState = HUNT;
                    if (asi_in0_endofpacket) begin
                        w_pktInc = 1'b1;
                    end else begin
                        w_errLength = 1'b1;
                    end
                end else if (asi_in0_endofpacket) begin
                    w_loadEop   = 1'b1;
                    w_errLength = 1'b1;
                    w_nextState = HUNT;
                end else begin
                    w_nextCnt = r_symCnt + CW'(1);
                end
            end
        end
    end

    // Framing FSM, status outputs and the symbol serializer.
    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            r_state      <= HUNT;
            r_symCnt     <= '0;
            r_hold       <= '0;
            r_busy       <= 1'b0;
            r_idx        <= '0;
            r_sopFlag    <= 1'b0;
            r_eopFlag    <= 1'b0;
            r_errFraming <= 1'b0;
            r_errLength  <= 1'b0;
            r_pktCount   <= '0;
        end else begin
            r_state      <= w_nextState;
            r_symCnt     <= w_nextCnt;
            r_errFraming <= w_errFraming;
            r_errLength  <= w_errLength;
            if (w_pktInc) begin
                r_pktCount <= r_pktCount + 16'd1;
            end
            if (w_load) begin
                r_hold    <= asi_in0_data;
                r_busy    <= 1'b1;
                r_idx     <= '0;
                r_sopFlag <= w_loadSop;
                r_eopFlag <= w_loadEop;
            end else if (w_outXfer) begin
                if (w_lastByte) begin
                    r_busy <= 1'b0;
                    r_idx  <= '0;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

    // Byte select: byte 0 sits in the most significant bits of the symbol.
    always_comb begin
        w_byte = '0;
        for (int k = 0; k < BYTES_PER_SYMBOL; k++) begin
            if (r_idx == IW'(k)) begin
                w_byte = r_hold[(BYTES_PER_SYMBOL - k) * BITS_PER_BYTES - 1 -: BITS_PER_BYTES];
            end
        end
    end

    assign aso_out0_data          = w_byte;
    assign aso_out0_valid         = r_busy;
    assign aso_out0_startofpacket = r_busy && r_sopFlag && (r_idx == '0);
    assign aso_out0_endofpacket   = r_busy && r_eopFlag && w_lastByte;
    assign err_framing            = r_errFraming;
    assign err_length             = r_errLength;
    assign pkt_count              = r_pktCount;

endmodule
